player_action_scheduler: RTL

//  Sequences per-player actions from the debounced, clk_game-synchronous button levels.

---
 rtl/player_action_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/player_action_scheduler.sv
// Two-player action sequencer: attack FSMs, paced moves, round-robin hit/clash arbitration, hit-stagger.
// Optional feature macro ATTACK_BUFFER_EN: 1-deep per-player attack buffer latched during RECOVER.
module player_action_scheduler #(
  parameter int WINDUP_CYC  = 4,
  parameter int ACTIVE_CYC  = 3,
  parameter int RECOVER_CYC = 6,
  parameter int MOVE_PERIOD = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p1_attack,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic       p2_attack,
  input  logic       in_range,
  input  logic       freeze,
  output logic       p1_move_l,
  output logic       p1_move_r,
  output logic       p2_move_l,
  output logic       p2_move_r,
  output logic [1:0] p1_state,
  output logic [1:0] p2_state,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       clash
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDUP  = 2'd1,
    ACTIVE  = 2'd2,
    RECOVER = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WINDUP_LAST  = CNT_W'(WINDUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ACTIVE_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST    = CNT_W'(MOVE_PERIOD - 1);

  state_t           st        [2];
  logic [CNT_W-1:0] phase_cnt [2];
  logic [CNT_W-1:0] move_cnt  [2];
  logic [1:0]       move_dir  [2];  // {left,right} direction currently being paced
  logic [1:0]       hit_done;
  logic [1:0]       prev_attack;
  logic [1:0]       hit_q;
  logic [1:0]       move_l_q;
  logic [1:0]       move_r_q;
  logic             clash_q;
  logic             prio;           // 0: P1 wins the next clash, 1: P2

  logic [1:0]       attack;
  logic [1:0]       left;
  logic [1:0]       right;
  logic [1:0]       atk_edge;
  logic [1:0]       start_req;
  logic [1:0]       elig;
  logic [1:0]       win;
  logic [1:0]       stagger;
  logic [1:0]       move_ok;
  logic [1:0]       move_fire;
  logic [1:0]       dir       [2];
  logic [CNT_W-1:0] move_base [2];
  logic [CNT_W-1:0] move_next [2];

  assign attack   = {p2_attack, p1_attack};
  assign left     = {p2_left, p1_left};
  assign right    = {p2_right, p1_right};
  assign atk_edge = attack & ~prev_attack;

`ifdef ATTACK_BUFFER_EN
  logic [1:0] atk_buf;
  assign start_req = atk_edge | atk_buf;
`else
  assign start_req = atk_edge;
`endif

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = (st[i] == ACTIVE) && in_range && !hit_done[i] && !freeze;
    end
    win[0]     = elig[0] & (~elig[1] | ~prio);
    win[1]     = elig[1] & (~elig[0] | prio);
    stagger[0] = win[1] && (st[0] == WINDUP);
    stagger[1] = win[0] && (st[1] == WINDUP);
    // A change of held direction restarts pacing so the new direction pulses at once.
    for (int i = 0; i < 2; i++) begin
      dir[i]       = {left[i] & ~right[i], right[i] & ~left[i]};
      move_ok[i]   = (st[i] == IDLE) && !freeze && (dir[i] != 2'b00);
      move_base[i] = (move_ok[i] && dir[i] == move_dir[i]) ? move_cnt[i] : '0;
      move_fire[i] = move_ok[i] && (move_base[i] == '0);
      move_next[i] = (!move_ok[i] || move_base[i] == MOVE_LAST) ? '0 : move_base[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        st[i]        <= IDLE;
        phase_cnt[i] <= '0;
        move_cnt[i]  <= '0;
        move_dir[i]  <= 2'b00;
      end
      hit_done    <= 2'b00;
      prev_attack <= 2'b11;
      hit_q       <= 2'b00;
      move_l_q    <= 2'b00;
      move_r_q    <= 2'b00;
      clash_q     <= 1'b0;
      prio        <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      atk_buf     <= 2'b00;
`endif
    end else begin
      prev_attack <= attack;
      if (freeze) begin
        for (int i = 0; i < 2; i++) begin
          st[i]        <= IDLE;
          phase_cnt[i] <= '0;
          move_cnt[i]  <= '0;
          move_dir[i]  <= 2'b00;
        end
        hit_done <= 2'b00;
        hit_q    <= 2'b00;
        move_l_q <= 2'b00;
        move_r_q <= 2'b00;
        clash_q  <= 1'b0;
`ifdef ATTACK_BUFFER_EN
        atk_buf  <= 2'b00;
`endif
      end else begin
        hit_q   <= win;
        clash_q <= &elig;
        if (&elig) prio <= ~prio;
        for (int i = 0; i < 2; i++) begin
          move_l_q[i] <= move_fire[i] & dir[i][1];
          move_r_q[i] <= move_fire[i] & dir[i][0];
          move_cnt[i] <= move_next[i];
          move_dir[i] <= move_ok[i] ? dir[i] : 2'b00;
          if (win[i] || (&elig)) hit_done[i] <= 1'b1;
`ifdef ATTACK_BUFFER_EN
          if (st[i] == IDLE) atk_buf[i] <= 1'b0;
          else if (st[i] == RECOVER && atk_edge[i]) atk_buf[i] <= 1'b1;
`endif
          case (st[i])
            IDLE: begin
              if (start_req[i]) begin
                st[i]        <= WINDUP;
                phase_cnt[i] <= '0;
                hit_done[i]  <= 1'b0;
              end
            end
            WINDUP: begin
              if (stagger[i]) begin
                st[i]        <= RECOVER;
                phase_cnt[i] <= '0;
              end else if (phase_cnt[i] == WINDUP_LAST) begin
                st[i]        <= ACTIVE;
                phase_cnt[i] <= '0;
              end else begin
                phase_cnt[i] <= phase_cnt[i] + CNT_W'(1);
              end
            end
            ACTIVE: begin
              if (phase_cnt[i] == ACTIVE_LAST) begin
                st[i]        <= RECOVER;
                phase_cnt[i] <= '0;
              end else begin
                phase_cnt[i] <= phase_cnt[i] + CNT_W'(1);
              end
            end
            RECOVER: begin
              if (phase_cnt[i] == RECOVER_LAST) begin
                st[i]        <= IDLE;
                phase_cnt[i] <= '0;
              end else begin
                phase_cnt[i] <= phase_cnt[i] + CNT_W'(1);
              end
            end
            default: st[i] <= IDLE;
          endcase
        end
      end
    end
  end

  assign p1_state  = st[0];
  assign p2_state  = st[1];
  assign p1_hit    = hit_q[0];
  assign p2_hit    = hit_q[1];
  assign clash     = clash_q;
  assign p1_move_l = move_l_q[0];
  assign p1_move_r = move_r_q[0];
  assign p2_move_l = move_l_q[1];
  assign p2_move_r = move_r_q[1];

endmodule
